// File: rtl/uart_rx_fifo.sv
// ============================================================================
// uart_rx_fifo : edge-detected UART byte capture into a FWFT circular FIFO.
// Optional: define UART_RX_FIFO_OVF_CNT_EN to add the ovf_count output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_ready,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ack,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  overflow,
  input  logic                  ovf_clr
`ifdef UART_RX_FIFO_OVF_CNT_EN
  ,
  output logic [7:0]            ovf_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                rx_ready_q;
  logic                push;
  logic                pop;
  logic                wr_en;
  logic                drop;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign count     = wr_ptr - rd_ptr;
  assign out_valid = (wr_ptr != rd_ptr);
  assign full      = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign out_data  = out_valid ? mem[rd_ptr[DEPTH_LOG2-1:0]] : 8'h00;

  assign push  = rx_ready & ~rx_ready_q;
  assign pop   = out_ack & out_valid;
  // A simultaneous pop frees the head slot, so a full FIFO can still accept.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= rx_data;
    end
  end

  // rx_ready_q resets high so a byte pending across reset release is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rx_ready_q <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      rx_ready_q <= rx_ready;
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef UART_RX_FIFO_OVF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count <= 8'h00;
    end else if (drop) begin
      if (ovf_clr) begin
        ovf_count <= 8'h01;
      end else if (ovf_count != 8'hFF) begin
        ovf_count <= ovf_count + 8'd1;
      end
    end else if (ovf_clr) begin
      ovf_count <= 8'h00;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// tb_uart_rx_fifo : scoreboard bench, a depth-16 and a depth-4 instance.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data  [2];
  logic       rx_ready [2];
  logic       out_ack  [2];
  logic       ovf_clr  [2];
  logic [7:0] out_data [2];
  logic       out_valid[2];
  logic       full     [2];
  logic       overflow [2];
  logic [4:0] count_a;
  logic [2:0] count_b;
`ifdef UART_RX_FIFO_OVF_CNT_EN
  logic [7:0] ovf_cnt  [2];
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #10 clk = ~clk;

  uart_rx_fifo #(.DEPTH_LOG2(4)) dut_a (
    .clk(clk), .rst(rst), .rx_data(rx_data[0]), .rx_ready(rx_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ack(out_ack[0]),
    .count(count_a), .full(full[0]), .overflow(overflow[0]), .ovf_clr(ovf_clr[0])
`ifdef UART_RX_FIFO_OVF_CNT_EN
    , .ovf_count(ovf_cnt[0])
`endif
  );

  uart_rx_fifo #(.DEPTH_LOG2(2)) dut_b (
    .clk(clk), .rst(rst), .rx_data(rx_data[1]), .rx_ready(rx_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ack(out_ack[1]),
    .count(count_b), .full(full[1]), .overflow(overflow[1]), .ovf_clr(ovf_clr[1])
`ifdef UART_RX_FIFO_OVF_CNT_EN
    , .ovf_count(ovf_cnt[1])
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input int i, input logic [7:0] d, input int hold, input bit keep);
    rx_data[i]  = d;
    rx_ready[i] = 1'b1;
    if (keep) begin
      if (i == 0) q0.push_back(d);
      else        q1.push_back(d);
    end
    repeat (hold) step();
    rx_ready[i] = 1'b0;
    step();
  endtask

  task automatic ack(input int i);
    out_ack[i] = 1'b1;
    step();
    out_ack[i] = 1'b0;
  endtask

  // Monitor: every accepted pop must present the oldest expected byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid[0] && out_ack[0]) begin
        if (q0.size() == 0) check("pop_a_unexpected", 1, 0);
        else check("pop_a_data", int'(out_data[0]), int'(q0.pop_front()));
      end
      if (out_valid[1] && out_ack[1]) begin
        if (q1.size() == 0) check("pop_b_unexpected", 1, 0);
        else check("pop_b_data", int'(out_data[1]), int'(q1.pop_front()));
      end
      if (!out_valid[0]) check("idle_a_data", int'(out_data[0]), 0);
      if (!out_valid[1]) check("idle_b_data", int'(out_data[1]), 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rx_data[i] = 8'hA5; rx_ready[i] = 1'b1; out_ack[i] = 1'b0; ovf_clr[i] = 1'b0;
    end
    repeat (3) step();
    check("rst_count_a", int'(count_a), 0);
    check("rst_valid_a", int'(out_valid[0]), 0);
    check("rst_data_a", int'(out_data[0]), 0);
    check("rst_full_a", int'(full[0]), 0);
    check("rst_ovf_a", int'(overflow[0]), 0);
    check("rst_count_b", int'(count_b), 0);
`ifdef UART_RX_FIFO_OVF_CNT_EN
    check("rst_ovfcnt_a", int'(ovf_cnt[0]), 0);
`endif
    rst = 1'b0;

    // Byte pending across reset release must not be pushed.
    repeat (20) step();
    check("inflight_count", int'(count_a), 0);
    check("inflight_valid", int'(out_valid[0]), 0);
    rx_ready[0] = 1'b0; rx_ready[1] = 1'b0;
    step();
    rx_data[0] = 8'h3C; rx_ready[0] = 1'b1; q0.push_back(8'h3C);
    step();
    check("first_valid", int'(out_valid[0]), 1);
    check("first_data", int'(out_data[0]), 8'h3C);
    check("first_count", int'(count_a), 1);
    repeat (3) step();
    rx_ready[0] = 1'b0;
    step();
    ack(0);
    check("first_drain", int'(count_a), 0);

    // Long rx_ready pulses: one push each.
    for (int d = 1; d <= 5; d++) push_byte(0, 8'(d), 100, 1'b1);
    check("five_count", int'(count_a), 5);
    repeat (5) ack(0);
    check("five_valid", int'(out_valid[0]), 0);
    check("five_data", int'(out_data[0]), 0);

    // Depth 4: overfill by two.
    for (int d = 8'h10; d <= 8'h15; d++) push_byte(1, 8'(d), 3, d < 8'h14);
    check("ovf_full", int'(full[1]), 1);
    check("ovf_count4", int'(count_b), 4);
    check("ovf_flag", int'(overflow[1]), 1);
`ifdef UART_RX_FIFO_OVF_CNT_EN
    check("ovf_cnt2", int'(ovf_cnt[1]), 2);
`endif
    ovf_clr[1] = 1'b1; step(); ovf_clr[1] = 1'b0;
    check("ovf_cleared", int'(overflow[1]), 0);
`ifdef UART_RX_FIFO_OVF_CNT_EN
    check("ovf_cnt_cleared", int'(ovf_cnt[1]), 0);
`endif

    // Push and pop together while full.
    rx_data[1] = 8'hEE; rx_ready[1] = 1'b1; out_ack[1] = 1'b1; q1.push_back(8'hEE);
    step();
    out_ack[1] = 1'b0;
    check("fullpp_count", int'(count_b), 4);
    check("fullpp_ovf", int'(overflow[1]), 0);
    check("fullpp_head", int'(out_data[1]), 8'h11);
    rx_ready[1] = 1'b0;
    step();
    repeat (4) ack(1);
    check("fullpp_drain", int'(count_b), 0);

    // Wrap the pointers several times.
    for (int d = 8'h20; d <= 8'h29; d++) begin
      push_byte(1, 8'(d), 2, 1'b1);
      ack(1);
    end
    check("wrap_count", int'(count_b), 0);
    ovf_clr[1] = 1'b1; step(); ovf_clr[1] = 1'b0;
    check("clr_noop", int'(overflow[1]), 0);
    ack(1);
    check("empty_ack_count", int'(count_b), 0);
    check("empty_ack_valid", int'(out_valid[1]), 0);

    // Drop coinciding with ovf_clr: set wins.
    for (int d = 8'h30; d <= 8'h33; d++) push_byte(1, 8'(d), 1, 1'b1);
    rx_data[1] = 8'h34; rx_ready[1] = 1'b1; ovf_clr[1] = 1'b1;
    step();
    ovf_clr[1] = 1'b0; rx_ready[1] = 1'b0;
    check("prio_ovf", int'(overflow[1]), 1);
`ifdef UART_RX_FIFO_OVF_CNT_EN
    check("prio_ovfcnt", int'(ovf_cnt[1]), 1);
`endif

    // Asynchronous reset mid-stream.
    for (int d = 8'h40; d <= 8'h42; d++) push_byte(0, 8'(d), 1, 1'b1);
    check("pre_rst_count", int'(count_a), 3);
    #5;
    rst = 1'b1;
    #1;
    check("async_count", int'(count_a), 0);
    check("async_valid", int'(out_valid[0]), 0);
    check("async_ovf_b", int'(overflow[1]), 0);
    check("async_count_b", int'(count_b), 0);
    q0.delete();
    q1.delete();
    step();
    rst = 1'b0;
    step();
    push_byte(0, 8'h55, 2, 1'b1);
    check("post_rst_data", int'(out_data[0]), 8'h55);
    ack(0);
    check("post_rst_count", int'(count_a), 0);
    check("sb_empty_a", q0.size(), 0);
    check("sb_empty_b", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
